// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - HOLD/HLDA bus owner running T1/T2/T3 memory cycles for CPU and DMA
module bus_arbiter #(
  parameter logic [3:0] WAIT_RD = 4'd1,
  parameter logic [3:0] WAIT_WR = 4'd1
) (
  input  logic        clock,
  input  logic        reset_in,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [15:0] cpu_add,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ready,
  input  logic        dma_req,
  input  logic        dma_wr,
  input  logic [15:0] dma_add,
  input  logic [7:0]  dma_wdata,
  output logic        dma_ready,
  output logic [7:0]  rdata,
  input  logic        hold,
  output logic        hlda,
  output logic [15:0] mem_add,
  inout  wire  [7:0]  mem_data,
  output logic        mem_rdn,
  output logic        mem_wrn,
  input  logic        mem_ready
);

  typedef enum logic [1:0] {S_IDLE, S_T1, S_T2, S_T3} state_t;

  state_t      state;
  logic        cur_wr;
  logic [7:0]  wdata_q;
  logic [3:0]  wait_cnt;

  logic        own_req;
  logic        own_wr;
  logic [15:0] own_add;
  logic [7:0]  own_wdata;

  // hlda is the owner register: the non-owner's request is simply not looked at
  assign own_req   = hlda ? dma_req   : cpu_req;
  assign own_wr    = hlda ? dma_wr    : cpu_wr;
  assign own_add   = hlda ? dma_add   : cpu_add;
  assign own_wdata = hlda ? dma_wdata : cpu_wdata;

  assign mem_data = (state != S_IDLE && cur_wr) ? wdata_q : 8'bz;

  always_ff @(posedge clock or negedge reset_in) begin
    if (!reset_in) begin
      state     <= S_IDLE;
      hlda      <= 1'b0;
      cpu_ready <= 1'b0;
      dma_ready <= 1'b0;
      mem_rdn   <= 1'b1;
      mem_wrn   <= 1'b1;
      mem_add   <= 16'h0000;
      rdata     <= 8'h00;
      cur_wr    <= 1'b0;
      wdata_q   <= 8'h00;
      wait_cnt  <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (hold && !hlda) begin
            hlda <= 1'b1;
          end else if (!hold && hlda) begin
            hlda <= 1'b0;
          end else if (own_req) begin
            cur_wr  <= own_wr;
            mem_add <= own_add;
            wdata_q <= own_wdata;
            state   <= S_T1;
          end
        end
        S_T1: begin
          wait_cnt <= cur_wr ? WAIT_WR : WAIT_RD;
          mem_rdn  <= cur_wr;
          mem_wrn  <= !cur_wr;
          state    <= S_T2;
        end
        S_T2: begin
          // minimum wait count must expire before mem_ready is honoured
          if (wait_cnt == 4'd0 && mem_ready) begin
            mem_rdn   <= 1'b1;
            mem_wrn   <= 1'b1;
            cpu_ready <= !hlda;
            dma_ready <= hlda;
            if (!cur_wr) rdata <= mem_data;
            state     <= S_T3;
          end else if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_T3: begin
          cpu_ready <= 1'b0;
          dma_ready <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
